// File: rtl/gyroscope_data_sys_piobp_irq_master.sv
`default_nettype none
// ============================================================================
// Module      : gyroscope_data_sys_piobp_irq_master
// Description : Avalon-MM initiator that services the pushbutton PIO interrupt
//               in hardware: arms the mask, reads/clears edge capture, samples
//               the button level, reports a press event and applies a holdoff.
// Revision    : 1.0 - initial release
// ============================================================================
module gyroscope_data_sys_piobp_irq_master #(
    parameter int HOLDOFF_CYCLES = 50000,
    parameter int COUNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               irq,
    output logic [1:0]         avm_address,
    output logic               avm_chipselect,
    output logic               avm_write_n,
    output logic [31:0]        avm_writedata,
    input  logic [31:0]        avm_readdata,
    output logic               event_valid,
    output logic               event_level,
    output logic [COUNT_W-1:0] event_count,
    output logic               busy
);

    localparam logic [1:0] c_ADDR_DATA = 2'd0;
    localparam logic [1:0] c_ADDR_MASK = 2'd2;
    localparam logic [1:0] c_ADDR_EDGE = 2'd3;

    localparam int c_HO_W = (HOLDOFF_CYCLES > 2) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [c_HO_W-1:0] c_HO_LAST =
        c_HO_W'((HOLDOFF_CYCLES > 0) ? (HOLDOFF_CYCLES - 1) : 0);

    typedef enum logic [3:0] {
        ST_RST_WAIT     = 4'd0,
        ST_INIT_MASK    = 4'd1,
        ST_INIT_CLR     = 4'd2,
        ST_IDLE         = 4'd3,
        ST_RD_CAP       = 4'd4,
        ST_RD_CAP_WAIT  = 4'd5,
        ST_CLR_CAP      = 4'd6,
        ST_RD_DATA      = 4'd7,
        ST_RD_DATA_WAIT = 4'd8,
        ST_REPORT       = 4'd9,
        ST_HOLDOFF      = 4'd10,
        ST_HO_CLR       = 4'd11
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_HO_W-1:0]   r_ho_cnt;
    logic [COUNT_W-1:0]  r_count;
    logic                r_level;

    // Only bit 0 of the PIO carries the button.
    logic w_rd_unused;
    assign w_rd_unused = ^avm_readdata[31:1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RST_WAIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_RST_WAIT:     w_next = ST_INIT_MASK;
            ST_INIT_MASK:    w_next = ST_INIT_CLR;
            ST_INIT_CLR:     w_next = ST_IDLE;
            ST_IDLE: begin
                if (irq && enable) begin
                    w_next = ST_RD_CAP;
                end
            end
            ST_RD_CAP:       w_next = ST_RD_CAP_WAIT;
            // A cleared capture bit means the interrupt was spurious.
            ST_RD_CAP_WAIT:  w_next = avm_readdata[0] ? ST_CLR_CAP : ST_IDLE;
            ST_CLR_CAP:      w_next = ST_RD_DATA;
            ST_RD_DATA:      w_next = ST_RD_DATA_WAIT;
            ST_RD_DATA_WAIT: w_next = ST_REPORT;
            ST_REPORT:       w_next = (HOLDOFF_CYCLES == 0) ? ST_HO_CLR : ST_HOLDOFF;
            ST_HOLDOFF: begin
                if (r_ho_cnt == c_HO_LAST) begin
                    w_next = ST_HO_CLR;
                end
            end
            ST_HO_CLR:       w_next = ST_IDLE;
            default:         w_next = ST_RST_WAIT;
        endcase
    end

    always_comb begin
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_address    = c_ADDR_DATA;
        avm_writedata  = 32'd0;
        case (r_state)
            ST_INIT_MASK: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = c_ADDR_MASK;
                avm_writedata  = 32'd1;
            end
            ST_INIT_CLR, ST_CLR_CAP, ST_HO_CLR: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                avm_address    = c_ADDR_EDGE;
            end
            ST_RD_CAP: begin
                avm_chipselect = 1'b1;
                avm_address    = c_ADDR_EDGE;
            end
            ST_RD_DATA: begin
                avm_chipselect = 1'b1;
                avm_address    = c_ADDR_DATA;
            end
            default: begin
                avm_chipselect = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ho_cnt <= '0;
        end else if (r_state == ST_REPORT) begin
            r_ho_cnt <= '0;
        end else if (r_state == ST_HOLDOFF) begin
            r_ho_cnt <= r_ho_cnt + c_HO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_level <= 1'b1;
        end else begin
            if (r_state == ST_RD_DATA_WAIT) begin
                r_level <= avm_readdata[0];
            end
            if (r_state == ST_REPORT) begin
                r_count <= r_count + COUNT_W'(1);
            end
        end
    end

    assign event_valid = (r_state == ST_REPORT);
    assign event_level = r_level;
    assign event_count = r_count;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire
